mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte-address width of all address ports.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- if_req  in  1  instruction-fetch request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid on rdata
- d_req  in  1  data request
- d_addr  in  ADDR_W  data address
- d_wen  in  4  byte write enables; 0 = read
- d_wdata  in  32  data write value
- d_gnt  out  1  data accepted
- d_rvalid  out  1  data read valid
- x_req  in  1  external (loader/debug) request
- x_lock  in  1  external holds port across consecutive grants
- x_addr  in  ADDR_W  external address
- x_wen  in  4  external byte enables
- x_wdata  in  32  external write value
- x_gnt  out  1  external accepted
- x_rvalid  out  1  external read valid
- rdata  out  32  shared read data
- m_en  out  1  SRAM access enable
- m_addr  out  ADDR_W  SRAM address
- m_wen  out  4  SRAM byte enables
- m_wdata  out  32  SRAM write data
- m_rdata  in  32  SRAM read data, one cycle after m_en
- busy_cnt  out  16  saturating count of cycles with m_en=1

Function
REQ-003 SHALL grant at most one requester per cycle; gnt is combinational from req and arbiter state, same cycle.
REQ-004 SHALL drive m_en/m_addr/m_wen/m_wdata from the granted requester in the grant cycle; when none is granted: m_en=0, all other m_* outputs 0.
REQ-005 SHALL assert <p>_rvalid exactly one cycle after a granted read (wen=0); rdata = m_rdata in that cycle, 0 otherwise; writes SHALL produce no rvalid.
REQ-006 SHALL support back-to-back grants every cycle (fully pipelined, one outstanding read max).
REQ-007 SHALL arbitrate round-robin over order if,d,x: a 2-bit pointer holds the last granted port; search starts at the next port; the pointer updates only on a grant.
REQ-008 SHALL, in state LOCKED, grant only x while x_req=1; FSM states IDLE->LOCKED on an x grant with x_lock=1; LOCKED->IDLE on a cycle with x_lock=0 or x_req=0 (no grant to x in that cycle unless x wins arbitration normally).
REQ-009 SHALL keep requests un-granted while req is held; a requester may drop req without penalty.
REQ-010 SHALL increment busy_cnt on every m_en=1 cycle, saturating at 0xFFFF.
REQ-011 SHALL keep gnt low for any port whose req=0, including in LOCKED.

Reset
REQ-012 SHALL on rstn=0 asynchronously clear: all gnt/rvalid, rdata, m_* outputs, busy_cnt to 0; pointer to 2 (so if wins first); FSM to IDLE.
REQ-013 SHALL discard a read in flight when reset asserts mid-access: no rvalid after deassertion.

Configuration
REQ-014 SHALL honour macro MEM_ARBITER_X_PRIORITY_EN: defined -> x has fixed highest priority over round-robin of if,d (pointer covers if,d only); undefined -> three-way round-robin per REQ-007.

Verification
REQ-015 Reset: rstn low mid-read -> rvalid stays 0; after release busy_cnt=0, m_en=0.
REQ-016 if_req=d_req=1 continuously, both reads -> grants alternate if,d,if,d; each rvalid one cycle after its grant with rdata=m_rdata.
REQ-017 All three req=1 constantly -> grant order if,d,x repeating; with MEM_ARBITER_X_PRIORITY_EN x granted every cycle.
REQ-018 x_req=x_lock=1 for 4 cycles with if_req=1 -> x granted 4 consecutive cycles, if granted the cycle after x_lock drops.
REQ-019 d write addr 0x10, wen=0xF, wdata=0xDEADBEEF -> m_en=1, m_wen=0xF same cycle, no d_rvalid; following read of 0x10 returns 0xDEADBEEF.
REQ-020 Force 0x10000 active cycles -> busy_cnt holds 0xFFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
// Three-port (fetch / data / external) arbiter onto one single-cycle SRAM port, with external lock support.
// Build option: define MEM_ARBITER_X_PRIORITY_EN to give x fixed priority over a two-way if/d round-robin.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [3:0]        d_wen,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  input  logic              x_req,
  input  logic              x_lock,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [3:0]        x_wen,
  input  logic [31:0]       x_wdata,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [31:0]       rdata,
  output logic              m_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_wen,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic [15:0]       busy_cnt
);
  localparam logic [1:0] P_IF = 2'd0, P_D = 2'd1, P_X = 2'd2;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [1:0] ptr;
  logic [2:0] gnt;      // {x, d, if}
  logic [2:0] rd_pend;  // read issued last cycle, per port

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (gnt[2] && x_lock)   state_nxt = LOCKED;
      LOCKED:  if (!(x_req && x_lock)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant select; search begins one past the last granted port.
  always_comb begin
    gnt = '0;
`ifdef MEM_ARBITER_X_PRIORITY_EN
    if (x_req)                              gnt = 3'b100;
    else if (if_req && (ptr != P_IF || !d_req)) gnt = 3'b001;
    else if (d_req)                         gnt = 3'b010;
`else
    if (state == LOCKED && x_req && x_lock) gnt = 3'b100;
    else begin
      unique case (ptr)
        P_IF:    gnt = d_req  ? 3'b010 : x_req ? 3'b100 : if_req ? 3'b001 : 3'b000;
        P_D:     gnt = x_req  ? 3'b100 : if_req ? 3'b001 : d_req ? 3'b010 : 3'b000;
        default: gnt = if_req ? 3'b001 : d_req ? 3'b010 : x_req ? 3'b100 : 3'b000;
      endcase
    end
`endif
    if (!rstn) gnt = '0;
  end

  assign if_gnt = gnt[0];
  assign d_gnt  = gnt[1];
  assign x_gnt  = gnt[2];
  assign m_en   = |gnt;

  always_comb begin
    m_addr  = '0;
    m_wen   = '0;
    m_wdata = '0;
    if (gnt[0]) m_addr = if_addr;
    else if (gnt[1]) begin
      m_addr  = d_addr;
      m_wen   = d_wen;
      m_wdata = d_wdata;
    end else if (gnt[2]) begin
      m_addr  = x_addr;
      m_wen   = x_wen;
      m_wdata = x_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr <= P_X;
`ifdef MEM_ARBITER_X_PRIORITY_EN
    else if (gnt[0]) ptr <= P_IF;
    else if (gnt[1]) ptr <= P_D;
`else
    else if (gnt[0]) ptr <= P_IF;
    else if (gnt[1]) ptr <= P_D;
    else if (gnt[2]) ptr <= P_X;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_pend <= '0;
    else       rd_pend <= gnt & {x_wen == 4'd0, d_wen == 4'd0, 1'b1};
  end

  assign if_rvalid = rd_pend[0];
  assign d_rvalid  = rd_pend[1];
  assign x_rvalid  = rd_pend[2];
  assign rdata     = (|rd_pend) ? m_rdata : 32'd0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            busy_cnt <= '0;
    else if (m_en && busy_cnt != 16'hFFFF) busy_cnt <= busy_cnt + 16'd1;
  end
endmodule
